dmi_responder: RTL and testbench



---
 rtl/dmi_pkg.sv | 28 ++
 rtl/dmi_responder.sv | 151 +++++++++++++++
 tb/tb_dmi_responder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dmi_pkg.sv
// Shared encodings and default widths for the DMI responder.
package dmi_pkg;

  localparam int unsigned DMI_DATA_BITS      = 34;
  localparam int unsigned DMI_ADDR_BITS      = 5;
  localparam int unsigned DMI_OP_BITS        = 2;
  localparam int unsigned DMI_TIMEOUT_CYCLES = 16;
  localparam int unsigned DMI_TMO_BITS       = 8;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    RESP_OK   = 2'd0,
    RESP_FAIL = 2'd2
  } dmi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dmi_state_e;

endpackage

// File: rtl/dmi_responder.sv
// DMI request/response endpoint: accepts one DTM request at a time, runs it
// against a register backend with an ack timeout and returns a response.
// Ports:
//   clock, reset                 - sole clock, synchronous active-high reset
//   dtm_req_valid/ready/bits     - request channel, bits = {addr, data, op}
//   dtm_resp_valid/ready/bits    - response channel, bits = {data, resp}
//   reg_req_valid/write/addr/wdata - backend access request (held during ACCESS)
//   reg_ack/err/rdata            - backend completion pulse and its payload
module dmi_responder
  import dmi_pkg::*;
#(
  parameter int unsigned DEBUG_DATA_BITS = DMI_DATA_BITS,
  parameter int unsigned DEBUG_ADDR_BITS = DMI_ADDR_BITS,
  parameter int unsigned DEBUG_OP_BITS   = DMI_OP_BITS,
  parameter int unsigned TIMEOUT_CYCLES  = DMI_TIMEOUT_CYCLES
) (
  input  logic                                                  clock,
  input  logic                                                  reset,
  input  logic                                                  dtm_req_valid,
  output logic                                                  dtm_req_ready,
  input  logic [DEBUG_ADDR_BITS+DEBUG_DATA_BITS+DEBUG_OP_BITS-1:0] dtm_req_bits,
  output logic                                                  dtm_resp_valid,
  input  logic                                                  dtm_resp_ready,
  output logic [DEBUG_DATA_BITS+DEBUG_OP_BITS-1:0]              dtm_resp_bits,
  output logic                                                  reg_req_valid,
  output logic                                                  reg_req_write,
  output logic [DEBUG_ADDR_BITS-1:0]                            reg_req_addr,
  output logic [DEBUG_DATA_BITS-1:0]                            reg_req_wdata,
  input  logic                                                  reg_ack,
  input  logic                                                  reg_err,
  input  logic [DEBUG_DATA_BITS-1:0]                            reg_rdata
);

  localparam int unsigned DW = DEBUG_DATA_BITS;
  localparam int unsigned AW = DEBUG_ADDR_BITS;
  localparam int unsigned OW = DEBUG_OP_BITS;
  localparam logic [DMI_TMO_BITS-1:0] TMO_LAST = DMI_TMO_BITS'(TIMEOUT_CYCLES - 1);

  // Request field split
  logic [OW-1:0] req_op;
  logic [DW-1:0] req_data;
  logic [AW-1:0] req_addr;

  assign req_op   = dtm_req_bits[OW-1:0];
  assign req_data = dtm_req_bits[OW +: DW];
  assign req_addr = dtm_req_bits[OW+DW +: AW];

  dmi_state_e              state_q, state_d;
  logic                    req_ready_q, req_ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    reg_valid_q, reg_valid_d;
  logic                    write_q, write_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [DW-1:0]           wdata_q, wdata_d;
  logic [DW-1:0]           resp_data_q, resp_data_d;
  logic [OW-1:0]           resp_code_q, resp_code_d;
  logic [DMI_TMO_BITS-1:0] tmo_q, tmo_d;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_data_d = resp_data_q;
    resp_code_d = resp_code_q;
    tmo_d       = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (dtm_req_valid) begin
          addr_d  = req_addr;
          write_d = (req_op == OW'(OP_WRITE));
          // Reads present zero write data to the backend
          wdata_d = (req_op == OW'(OP_WRITE)) ? req_data : '0;
          tmo_d   = '0;
          if (req_op == OW'(OP_READ) || req_op == OW'(OP_WRITE)) begin
            state_d = ST_ACCESS;
          end else begin
            state_d     = ST_RESP;
            resp_data_d = '0;
            resp_code_d = (req_op == OW'(OP_NOP)) ? OW'(RESP_OK) : OW'(RESP_FAIL);
          end
        end
      end

      ST_ACCESS: begin
        // An ack in the final timeout cycle still completes the access
        if (reg_ack) begin
          state_d     = ST_RESP;
          resp_code_d = reg_err ? OW'(RESP_FAIL) : OW'(RESP_OK);
          resp_data_d = (reg_err || write_q) ? '0 : reg_rdata;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = ST_RESP;
          resp_code_d = OW'(RESP_FAIL);
          resp_data_d = '0;
        end else begin
          tmo_d = tmo_q + DMI_TMO_BITS'(1);
        end
      end

      ST_RESP: begin
        if (dtm_resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Handshake flags are decoded from the next state so they leave a flop
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
    reg_valid_d  = (state_d == ST_ACCESS);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      reg_valid_q  <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_data_q  <= '0;
      resp_code_q  <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      reg_valid_q  <= reg_valid_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_data_q  <= resp_data_d;
      resp_code_q  <= resp_code_d;
      tmo_q        <= tmo_d;
    end
  end

  assign dtm_req_ready  = req_ready_q;
  assign dtm_resp_valid = resp_valid_q;
  assign dtm_resp_bits  = {resp_data_q, resp_code_q};
  assign reg_req_valid  = reg_valid_q;
  assign reg_req_write  = write_q;
  assign reg_req_addr   = addr_q;
  assign reg_req_wdata  = wdata_q;

endmodule

// File: tb/tb_dmi_responder.sv
// Directed bench for dmi_responder (TIMEOUT_CYCLES = 4).
module tb_dmi_responder;

  localparam int unsigned DW = 34;
  localparam int unsigned AW = 5;
  localparam int unsigned OW = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              dtm_req_valid = 1'b0;
  logic              dtm_req_ready;
  logic [AW+DW+OW-1:0] dtm_req_bits = '0;
  logic              dtm_resp_valid;
  logic              dtm_resp_ready = 1'b0;
  logic [DW+OW-1:0]  dtm_resp_bits;
  logic              reg_req_valid;
  logic              reg_req_write;
  logic [AW-1:0]     reg_req_addr;
  logic [DW-1:0]     reg_req_wdata;
  logic              reg_ack = 1'b0;
  logic              reg_err = 1'b0;
  logic [DW-1:0]     reg_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  dmi_responder #(
    .DEBUG_DATA_BITS(DW),
    .DEBUG_ADDR_BITS(AW),
    .DEBUG_OP_BITS  (OW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .dtm_req_valid (dtm_req_valid),
    .dtm_req_ready (dtm_req_ready),
    .dtm_req_bits  (dtm_req_bits),
    .dtm_resp_valid(dtm_resp_valid),
    .dtm_resp_ready(dtm_resp_ready),
    .dtm_resp_bits (dtm_resp_bits),
    .reg_req_valid (reg_req_valid),
    .reg_req_write (reg_req_write),
    .reg_req_addr  (reg_req_addr),
    .reg_req_wdata (reg_req_wdata),
    .reg_ack       (reg_ack),
    .reg_err       (reg_err),
    .reg_rdata     (reg_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_req(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [OW-1:0] op);
    check("req_ready_before_send", 64'(dtm_req_ready), 64'd1);
    dtm_req_valid = 1'b1;
    dtm_req_bits  = {addr, data, op};
    tick();
    dtm_req_valid = 1'b0;
    dtm_req_bits  = '0;
  endtask

  task automatic finish_resp();
    dtm_resp_ready = 1'b1;
    tick();
    dtm_resp_ready = 1'b0;
    check("idle_req_ready", 64'(dtm_req_ready), 64'd1);
    check("idle_resp_valid", 64'(dtm_resp_valid), 64'd0);
  endtask

  task automatic ack(input logic err, input logic [DW-1:0] rdata);
    reg_ack   = 1'b1;
    reg_err   = err;
    reg_rdata = rdata;
    tick();
    reg_ack   = 1'b0;
    reg_err   = 1'b0;
    reg_rdata = '0;
  endtask

  initial begin
    int cnt;

    // Reset state
    tick();
    tick();
    check("rst_req_ready", 64'(dtm_req_ready), 64'd1);
    check("rst_resp_valid", 64'(dtm_resp_valid), 64'd0);
    check("rst_reg_valid", 64'(reg_req_valid), 64'd0);
    check("rst_resp_bits", 64'(dtm_resp_bits), 64'd0);
    check("rst_reg_addr", 64'(reg_req_addr), 64'd0);
    check("rst_reg_wdata", 64'(reg_req_wdata), 64'd0);
    reset = 1'b0;
    tick();

    // WRITE with ack after 3 cycles
    send_req(5'h04, 34'h1_2345_6789, 2'd2);
    check("wr_reg_valid", 64'(reg_req_valid), 64'd1);
    check("wr_reg_write", 64'(reg_req_write), 64'd1);
    check("wr_reg_addr", 64'(reg_req_addr), 64'h04);
    check("wr_reg_wdata", 64'(reg_req_wdata), 64'h1_2345_6789);
    check("wr_req_ready_busy", 64'(dtm_req_ready), 64'd0);
    check("wr_resp_valid_access", 64'(dtm_resp_valid), 64'd0);
    tick();
    tick();
    check("wr_wdata_stable", 64'(reg_req_wdata), 64'h1_2345_6789);
    ack(1'b0, 34'h3_0000_0001);
    check("wr_resp_valid", 64'(dtm_resp_valid), 64'd1);
    check("wr_resp_bits", 64'(dtm_resp_bits), 64'd0);
    check("wr_reg_valid_drop", 64'(reg_req_valid), 64'd0);
    finish_resp();

    // READ completed with backend error
    send_req(5'h09, 34'h0, 2'd1);
    ack(1'b1, 34'h1_1111_1111);
    check("err_resp_bits", 64'(dtm_resp_bits), 64'h2);
    finish_resp();

    // READ with data, then response held off for 5 cycles
    send_req(5'h11, 34'h0, 2'd1);
    check("rd_reg_write", 64'(reg_req_write), 64'd0);
    check("rd_reg_addr", 64'(reg_req_addr), 64'h11);
    check("rd_reg_wdata", 64'(reg_req_wdata), 64'd0);
    ack(1'b0, 34'h2_DEAD_BEEF);
    check("rd_reg_valid_drop", 64'(reg_req_valid), 64'd0);
    check("rd_resp_bits", 64'(dtm_resp_bits), {30'd0, 34'h2_DEAD_BEEF} << 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_resp_valid", 64'(dtm_resp_valid), 64'd1);
      check("stall_resp_bits", 64'(dtm_resp_bits), {30'd0, 34'h2_DEAD_BEEF} << 2);
      check("stall_req_ready", 64'(dtm_req_ready), 64'd0);
    end
    finish_resp();
    check("hold_resp_bits", 64'(dtm_resp_bits), {30'd0, 34'h2_DEAD_BEEF} << 2);

    // READ with no ack: times out after 4 ACCESS cycles
    send_req(5'h03, 34'h0, 2'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!reg_req_valid) break;
      cnt++;
      tick();
    end
    check("tmo_valid_cycles", 64'(cnt), 64'd4);
    check("tmo_resp_valid", 64'(dtm_resp_valid), 64'd1);
    check("tmo_resp_bits", 64'(dtm_resp_bits), 64'h2);
    ack(1'b0, 34'h0_1234_5678);
    check("late_ack_resp_bits", 64'(dtm_resp_bits), 64'h2);
    check("late_ack_reg_valid", 64'(reg_req_valid), 64'd0);
    finish_resp();
    ack(1'b0, 34'h0_1234_5678);
    check("idle_ack_resp_valid", 64'(dtm_resp_valid), 64'd0);
    check("idle_ack_resp_bits", 64'(dtm_resp_bits), 64'h2);

    // NOP then reserved op: immediate responses, no backend access
    send_req(5'h01, 34'h3_FFFF_FFFF, 2'd0);
    check("nop_resp_valid", 64'(dtm_resp_valid), 64'd1);
    check("nop_resp_bits", 64'(dtm_resp_bits), 64'd0);
    check("nop_reg_valid", 64'(reg_req_valid), 64'd0);
    finish_resp();
    send_req(5'h02, 34'h1_5555_5555, 2'd3);
    check("rsvd_resp_valid", 64'(dtm_resp_valid), 64'd1);
    check("rsvd_resp_bits", 64'(dtm_resp_bits), 64'h2);
    check("rsvd_reg_valid", 64'(reg_req_valid), 64'd0);
    finish_resp();

    // Reset during ACCESS abandons the transaction
    send_req(5'h07, 34'h0, 2'd1);
    check("rstacc_reg_valid_pre", 64'(reg_req_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstacc_req_ready", 64'(dtm_req_ready), 64'd1);
    check("rstacc_reg_valid", 64'(reg_req_valid), 64'd0);
    check("rstacc_resp_valid", 64'(dtm_resp_valid), 64'd0);
    check("rstacc_resp_bits", 64'(dtm_resp_bits), 64'd0);
    ack(1'b0, 34'h2_2222_2222);
    check("rstacc_stale_ack", 64'(dtm_resp_valid), 64'd0);
    send_req(5'h1F, 34'h0, 2'd1);
    check("post_rst_reg_addr", 64'(reg_req_addr), 64'h1F);
    ack(1'b0, 34'h1_5555_AAAA);
    check("post_rst_resp_bits", 64'(dtm_resp_bits), {30'd0, 34'h1_5555_AAAA} << 2);
    finish_resp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
